uart_bus_initiator: RTL and testbench

//  Bus initiator that streams bytes into the uart peripheral over its ds/rw/ack register bus.
//  Per byte: polls STATUS until the TX-busy bit clears, then writes the byte to DATA.

---
 rtl/uart_bus_initiator.sv | 214 +++++++++++++++++++++
 tb/tb_uart_bus_initiator.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_initiator
// Description : Streams bytes from a valid/ready producer into the uart
//               peripheral over its ds/rw/ack register bus. For every byte
//               it polls STATUS until the TX-busy bit clears, then writes
//               the byte to DATA. A per-cycle ack timeout aborts a stalled
//               bus cycle and drops the byte.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1  system clock, rising edge
//   reset_n     in   1  asynchronous active-low reset
//   in_data     in   8  byte to transmit
//   in_valid    in   1  in_data valid
//   in_ready    out  1  byte accepted on in_valid & in_ready
//   busy        out  1  high from accept until the sequence is finished
//   err         out  1  one-cycle pulse on ack timeout
//   addr        out  8  bus address
//   data_write  out  8  bus write data
//   data_read   in   8  bus read data, valid while ack=1
//   ds          out  1  data strobe (cycle request)
//   rw          out  1  1=read, 0=write
//   ack         in   1  responder acknowledge
// ============================================================================
module uart_bus_initiator #(
  parameter logic [7:0] DATA_ADDR   = 8'h00,
  parameter logic [7:0] STATUS_ADDR = 8'h01,
  parameter int         BUSY_BIT    = 1,
  parameter int         TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic       err,
  output logic [7:0] addr,
  output logic [7:0] data_write,
  input  logic [7:0] data_read,
  output logic       ds,
  output logic       rw,
  input  logic       ack
);

  localparam logic [7:0] c_TIMEOUT   = 8'(TIMEOUT);
  localparam logic [7:0] c_BUSY_MASK = 8'b1 << BUSY_BIT;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POLL      = 3'd1,
    S_POLL_GAP  = 3'd2,
    S_WRITE     = 3'd3,
    S_WRITE_GAP = 3'd4
  } state_t;

  state_t     r_state, w_state;
  logic       r_in_ready, w_in_ready;
  logic       r_busy, w_busy;
  logic       r_err, w_err;
  logic [7:0] r_addr, w_addr;
  logic [7:0] r_data_write, w_data_write;
  logic       r_ds, w_ds;
  logic       r_rw, w_rw;
  logic [7:0] r_byte, w_byte;
  logic       r_tx_busy, w_tx_busy;
  logic [7:0] r_cnt, w_cnt;

  logic [7:0] w_cnt_inc;
  logic       w_timeout;
  logic       w_status_busy;

  // The counter holds the number of ds-high cycles already spent without
  // ack; the cycle that would bring it to TIMEOUT is the abort cycle, so ds
  // is high for exactly TIMEOUT cycles. Ack is tested first so an ack on
  // that same cycle still completes the transfer.
  assign w_cnt_inc     = r_cnt + 8'd1;
  assign w_timeout     = (w_cnt_inc == c_TIMEOUT);
  // Only the busy bit matters; the remaining status bits are masked off.
  assign w_status_busy = |(data_read & c_BUSY_MASK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= 8'h00;
      r_data_write <= 8'h00;
      r_ds         <= 1'b0;
      r_rw         <= 1'b1;
      r_byte       <= 8'h00;
      r_tx_busy    <= 1'b0;
      r_cnt        <= 8'h00;
    end else begin
      r_state      <= w_state;
      r_in_ready   <= w_in_ready;
      r_busy       <= w_busy;
      r_err        <= w_err;
      r_addr       <= w_addr;
      r_data_write <= w_data_write;
      r_ds         <= w_ds;
      r_rw         <= w_rw;
      r_byte       <= w_byte;
      r_tx_busy    <= w_tx_busy;
      r_cnt        <= w_cnt;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_in_ready   = r_in_ready;
    w_busy       = r_busy;
    w_err        = 1'b0;
    w_addr       = r_addr;
    w_data_write = r_data_write;
    w_ds         = r_ds;
    w_rw         = r_rw;
    w_byte       = r_byte;
    w_tx_busy    = r_tx_busy;
    w_cnt        = r_cnt;

    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        // Accept only once in_ready is visible to the producer.
        if (in_valid && r_in_ready) begin
          w_byte     = in_data;
          w_in_ready = 1'b0;
          w_busy     = 1'b1;
          w_ds       = 1'b1;
          w_rw       = 1'b1;
          w_addr     = STATUS_ADDR;
          w_cnt      = 8'h00;
          w_state    = S_POLL;
        end
      end

      S_POLL: begin
        if (ack) begin
          w_tx_busy = w_status_busy;
          w_ds      = 1'b0;
          w_state   = S_POLL_GAP;
        end else if (w_timeout) begin
          w_ds    = 1'b0;
          w_err   = 1'b1;
          w_state = S_WRITE_GAP;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end

      S_POLL_GAP: begin
        // ds stays low until the responder has released ack.
        if (!ack) begin
          w_ds  = 1'b1;
          w_cnt = 8'h00;
          if (r_tx_busy) begin
            w_rw    = 1'b1;
            w_addr  = STATUS_ADDR;
            w_state = S_POLL;
          end else begin
            w_rw         = 1'b0;
            w_addr       = DATA_ADDR;
            w_data_write = r_byte;
            w_state      = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (ack) begin
          w_ds    = 1'b0;
          w_rw    = 1'b1;
          w_state = S_WRITE_GAP;
        end else if (w_timeout) begin
          w_ds    = 1'b0;
          w_rw    = 1'b1;
          w_err   = 1'b1;
          w_state = S_WRITE_GAP;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end

      S_WRITE_GAP: begin
        if (!ack) begin
          w_busy     = 1'b0;
          w_in_ready = 1'b1;
          w_state    = S_IDLE;
        end
      end

      default: begin
        w_state    = S_IDLE;
        w_ds       = 1'b0;
        w_rw       = 1'b1;
        w_busy     = 1'b0;
        w_in_ready = 1'b0;
      end
    endcase
  end

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign err        = r_err;
  assign addr       = r_addr;
  assign data_write = r_data_write;
  assign ds         = r_ds;
  assign rw         = r_rw;

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_bus_initiator
// Description : Self-checking bench for uart_bus_initiator. A negedge
//               responder model acks bus cycles after a programmable delay
//               and serves status bytes from a queue; a monitor records
//               transactions and bus-rule violations. Directed vectors come
//               from a table, random bytes are checked against a
//               transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_bus_initiator;

  localparam int         TIMEOUT = 8;
  localparam logic [7:0] c_BUSY_MASK = 8'h02;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       busy;
  logic       err;
  logic [7:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;
  logic       ds;
  logic       rw;
  logic       ack;

  uart_bus_initiator #(
    .DATA_ADDR  (8'h00),
    .STATUS_ADDR(8'h01),
    .BUSY_BIT   (1),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busy      (busy),
    .err       (err),
    .addr      (addr),
    .data_write(data_write),
    .data_read (data_read),
    .ds        (ds),
    .rw        (rw),
    .ack       (ack)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  typedef struct {
    string      name;
    logic [7:0] b;
    int         polls;
    logic [7:0] bval;
    logic [7:0] ival;
    int         rdd;
    int         wrd;
    int         h;
    int         e_reads;
    int         e_writes;
    int         e_err;
    int         e_lat;
    int         e_run;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // responder / monitor state
  int         rd_delay = 0, wr_delay = 0, ack_hold = 1;
  int         resp_cnt = 0, hold_left = 0;
  logic [7:0] status_q[$];
  txn_t       got_q[$];
  txn_t       mon_t;
  int         viol = 0, err_cycles = 0, ds_run = 0, max_run = 0;
  logic       prev_ds = 1'b0, prev_ack = 1'b0, prev_rw = 1'b1;
  logic [7:0] prev_addr = 8'h00, prev_wd = 8'h00;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Transaction-level expectation: each bus cycle lasts delay+1 ds-high
  // cycles and ends hold cycles later when ack is seen low; a cycle that
  // would need more than TIMEOUT ds-high cycles is cut at TIMEOUT and
  // followed by one gap cycle.
  function automatic void model(input int polls, input int rdd, input int wrd, input int h,
                                output int reads, output int writes, output int errs,
                                output int lat, output int run);
    if (rdd + 1 > TIMEOUT) begin
      reads = 0; writes = 0; errs = 1; lat = TIMEOUT + 1; run = TIMEOUT;
      return;
    end
    reads = polls + 1;
    lat   = reads * (rdd + h + 1);
    run   = rdd + 1;
    if (wrd + 1 > TIMEOUT) begin
      writes = 0; errs = 1; lat = lat + TIMEOUT + 1; run = TIMEOUT;
    end else begin
      writes = 1; errs = 0; lat = lat + wrd + h + 1;
      if (wrd + 1 > run) run = wrd + 1;
    end
  endfunction

  // Negedge: bus-rule monitor, then responder update.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (ds && prev_ds && (addr !== prev_addr || rw !== prev_rw || data_write !== prev_wd)) viol++;
      if (ds && !prev_ds && prev_ack) viol++;
      if (ds && prev_ds && prev_ack) viol++;
    end
    if (err) err_cycles++;
    if (ds) begin
      ds_run++;
      if (ds_run > max_run) max_run = ds_run;
    end else ds_run = 0;

    if (ack) begin
      if (hold_left > 1) hold_left--;
      else begin
        ack = 1'b0;
        data_read = 8'($urandom);
      end
    end else if (ds && reset_n) begin
      if (resp_cnt >= (rw ? rd_delay : wr_delay)) begin
        ack = 1'b1;
        hold_left = ack_hold;
        resp_cnt = 0;
        mon_t.rw = rw; mon_t.addr = addr; mon_t.data = data_write;
        got_q.push_back(mon_t);
        if (rw) begin
          if (status_q.size() > 0) data_read = status_q.pop_front();
          else data_read = 8'h00;
        end else data_read = 8'($urandom);
      end else resp_cnt++;
    end else resp_cnt = 0;

    prev_ds = ds; prev_ack = ack; prev_rw = rw; prev_addr = addr; prev_wd = data_write;
  end

  task automatic run_byte(input string tag, input logic [7:0] b, input int polls,
                          input logic [7:0] bval, input logic [7:0] ival,
                          input int rdd, input int wrd, input int h,
                          input int e_reads, input int e_writes, input int e_err,
                          input int e_lat, input int e_run);
    int cyc, nbusy, o_reads, o_writes, o_bad;
    bit seen_w;
    rd_delay = rdd; wr_delay = wrd; ack_hold = h;
    status_q.delete();
    for (int i = 0; i < polls; i++) status_q.push_back(bval);
    status_q.push_back(ival);
    got_q.delete(); err_cycles = 0; max_run = 0;
    in_data = b; in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " first cycle"}, {ds, rw, addr, busy, in_ready}, {1'b1, 1'b1, 8'h01, 1'b1, 1'b0});
    cyc = 0; nbusy = 0;
    while (!in_ready && cyc < 500) begin
      if (busy !== 1'b1) nbusy++;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0;
    o_reads = 0; o_writes = 0; o_bad = 0; seen_w = 1'b0;
    foreach (got_q[i]) begin
      if (got_q[i].rw && got_q[i].addr == 8'h01 && !seen_w) o_reads++;
      else if (!got_q[i].rw && got_q[i].addr == 8'h00 && got_q[i].data == b && !seen_w) begin
        o_writes++; seen_w = 1'b1;
      end else o_bad++;
    end
    check({tag, " latency"}, cyc, e_lat);
    check({tag, " busy during/after"}, {nbusy[15:0], 7'd0, busy}, 24'd0);
    check({tag, " status reads"}, o_reads, e_reads);
    check({tag, " data writes"}, o_writes, e_writes);
    check({tag, " stray txns"}, o_bad, 0);
    check({tag, " err cycles"}, err_cycles, e_err);
    check({tag, " longest ds"}, max_run, e_run);
  endtask

  int         cyc, nb, nw;
  int         polls, rdd, wrd, h, er, ew, ee, el, erun;
  logic [7:0] b, bv, iv;
  logic [16:0] t5_exp[4];

  initial begin
    reset_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; data_read = 8'h00; ack = 1'b0;

    vecs[0] = '{"T1 ack2", 8'h41, 0, 8'h00, 8'h00, 2, 2, 1, 1, 1, 0, 8, 3};
    vecs[1] = '{"T2 3 busy polls", 8'h5A, 3, 8'h02, 8'h00, 1, 1, 1, 4, 1, 0, 15, 2};
    vecs[2] = '{"T3 status FD", 8'hC3, 0, 8'h00, 8'hFD, 1, 1, 1, 1, 1, 0, 6, 2};
    vecs[3] = '{"busy FF hold2", 8'h00, 2, 8'hFF, 8'hFD, 0, 0, 2, 3, 1, 0, 12, 1};
    vecs[4] = '{"ack on timeout cycle", 8'h7E, 0, 8'h00, 8'h00, 7, 7, 1, 1, 1, 0, 18, 8};
    vecs[5] = '{"T4 read timeout", 8'h99, 0, 8'h00, 8'h00, 8, 0, 1, 0, 0, 1, 9, 8};
    vecs[6] = '{"write timeout", 8'hA5, 1, 8'h02, 8'h00, 0, 8, 1, 2, 0, 1, 13, 8};
    vecs[7] = '{"long ack hold", 8'h3C, 1, 8'h06, 8'h04, 3, 0, 3, 2, 1, 0, 18, 4};

    repeat (3) @(negedge clk);
    check("reset outputs", {ds, rw, addr, data_write, in_ready, busy, err},
          {1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
    reset_n = 1'b1;
    #1;
    check("in_ready before first edge", in_ready, 1'b0);
    @(negedge clk);
    check("idle after first edge", {in_ready, busy, ds}, 3'b100);

    foreach (vecs[i])
      run_byte(vecs[i].name, vecs[i].b, vecs[i].polls, vecs[i].bval, vecs[i].ival,
               vecs[i].rdd, vecs[i].wrd, vecs[i].h, vecs[i].e_reads, vecs[i].e_writes,
               vecs[i].e_err, vecs[i].e_lat, vecs[i].e_run);

    // T5: producer holds in_valid across two bytes
    rd_delay = 1; wr_delay = 1; ack_hold = 1;
    status_q.delete(); status_q.push_back(8'h00); status_q.push_back(8'h00);
    got_q.delete();
    in_data = 8'h01; in_valid = 1'b1;
    @(negedge clk);
    check("T5 first accept", {in_ready, busy}, 2'b01);
    in_data = 8'h02;
    cyc = 0; nb = 0;
    while (!in_ready && cyc < 100) begin
      if (busy !== 1'b1) nb++;
      @(negedge clk); cyc++;
    end
    check("T5 first latency", cyc, 6);
    @(negedge clk);
    check("T5 second accept", {in_ready, busy, ds}, 3'b011);
    in_valid = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      if (busy !== 1'b1) nb++;
      @(negedge clk); cyc++;
    end
    check("T5 second latency", cyc, 6);
    check("T5 busy while not ready", nb, 0);
    check("T5 txn count", got_q.size(), 4);
    t5_exp[0] = {1'b1, 8'h01, 8'h00};
    t5_exp[1] = {1'b0, 8'h00, 8'h01};
    t5_exp[2] = {1'b1, 8'h01, 8'h00};
    t5_exp[3] = {1'b0, 8'h00, 8'h02};
    for (int i = 0; i < 4; i++)
      if (i < got_q.size())
        check($sformatf("T5 txn%0d", i),
              {got_q[i].rw, got_q[i].addr, got_q[i].rw ? 8'h00 : got_q[i].data}, t5_exp[i]);

    // T6: reset while a write cycle is outstanding
    rd_delay = 1; wr_delay = 20; ack_hold = 1;
    status_q.delete(); status_q.push_back(8'h00);
    got_q.delete();
    in_data = 8'hE7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!(ds && !rw) && cyc < 100) begin @(negedge clk); cyc++; end
    @(negedge clk);
    check("T6 in write cycle", {ds, rw, addr, data_write}, {1'b1, 1'b0, 8'h00, 8'hE7});
    reset_n = 1'b0;
    #1;
    check("T6 async reset", {ds, in_ready, busy, rw}, 4'b0001);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("T6 idle after release", {in_ready, busy, ds}, 3'b100);
    nw = 0;
    foreach (got_q[i]) if (!got_q[i].rw) nw++;
    check("T6 dropped byte not written", nw, 0);
    run_byte("T6 next byte", 8'h6D, 0, 8'h00, 8'h00, 1, 1, 1, 1, 1, 0, 6, 2);

    // random bytes against the transaction-level model
    for (int k = 0; k < 40; k++) begin
      b     = 8'($urandom);
      polls = int'($urandom_range(0, 3));
      bv    = 8'($urandom) | c_BUSY_MASK;
      iv    = 8'($urandom) & ~c_BUSY_MASK;
      rdd   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 10)) : int'($urandom_range(0, 7));
      wrd   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 10)) : int'($urandom_range(0, 7));
      h     = int'($urandom_range(1, 3));
      model(polls, rdd, wrd, h, er, ew, ee, el, erun);
      run_byte($sformatf("rand%0d", k), b, polls, bv, iv, rdd, wrd, h, er, ew, ee, el, erun);
    end

    check("bus protocol violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
